// File: rtl/mul_fu_ctrl.sv
// Issue-side controller for the multi-cycle shift-add multiplier: decodes RV32M
// multiply ops, sequences the start/done handshake and returns tagged results on the CDB.
module mul_fu_ctrl #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned ROB_IDX_W = 5,
   parameter int unsigned PREG_W    = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_flush,
   input  logic                   i_iss_valid,
   output logic                   o_iss_ready,
   input  logic [2:0]             i_iss_funct3,
   input  logic [WIDTH-1:0]       i_iss_rs1_v,
   input  logic [WIDTH-1:0]       i_iss_rs2_v,
   input  logic [ROB_IDX_W-1:0]   i_iss_rob_idx,
   input  logic [PREG_W-1:0]      i_iss_pd,
   output logic                   o_mul_start,
   output logic [1:0]             o_mul_type,
   output logic [WIDTH-1:0]       o_mul_a,
   output logic [WIDTH-1:0]       o_mul_b,
   input  logic [2*WIDTH-1:0]     i_mul_p,
   input  logic                   i_mul_done,
   output logic                   o_cdb_valid,
   input  logic                   i_cdb_ready,
   output logic [ROB_IDX_W-1:0]   o_cdb_rob_idx,
   output logic [PREG_W-1:0]      o_cdb_pd,
   output logic [WIDTH-1:0]       o_cdb_data,
   output logic                   o_busy
);

   localparam int unsigned PW = 2 * WIDTH;

   localparam logic [1:0] MT_UU = 2'd0;
   localparam logic [1:0] MT_SS = 2'd1;
   localparam logic [1:0] MT_SU = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_BUSY   = 3'd1,
      S_RESULT = 3'd2,
      S_DRAIN  = 3'd3,
      S_COOL   = 3'd4
   } state_t;

   state_t              r_state;
   logic                r_hi_sel;
   logic                r_used;
   logic                r_mul_start;
   logic [1:0]          r_mul_type;
   logic [WIDTH-1:0]    r_mul_a;
   logic [WIDTH-1:0]    r_mul_b;
   logic                r_cdb_valid;
   logic [ROB_IDX_W-1:0] r_cdb_rob_idx;
   logic [PREG_W-1:0]   r_cdb_pd;
   logic [WIDTH-1:0]    r_cdb_data;
   logic                r_busy;

   logic [1:0]          w_dec_type;
   logic                w_dec_hi;
   logic                w_accept;
   logic                w_zero;
   logic [WIDTH-1:0]    w_sel;

   // funct3 decode; funct3[2]=1 never reaches this unit and falls back to MUL
   always_comb begin
      w_dec_type = MT_UU;
      w_dec_hi   = 1'b0;
      case (i_iss_funct3)
         3'b001: begin w_dec_type = MT_SS; w_dec_hi = 1'b1; end
         3'b010: begin w_dec_type = MT_SU; w_dec_hi = 1'b1; end
         3'b011: begin w_dec_type = MT_UU; w_dec_hi = 1'b1; end
         default: ;
      endcase
   end

   assign o_iss_ready = (r_state == S_IDLE) && !i_flush;
   assign w_accept    = i_iss_valid && o_iss_ready;
   assign w_zero      = (i_iss_rs1_v == '0) || (i_iss_rs2_v == '0);
   assign w_sel       = r_hi_sel ? i_mul_p[PW-1:WIDTH] : i_mul_p[WIDTH-1:0];

   // Control FSM; flush takes priority over done and CDB grant
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_hi_sel      <= 1'b0;
         r_used        <= 1'b0;
         r_mul_start   <= 1'b0;
         r_mul_type    <= MT_UU;
         r_mul_a       <= '0;
         r_mul_b       <= '0;
         r_cdb_valid   <= 1'b0;
         r_cdb_rob_idx <= '0;
         r_cdb_pd      <= '0;
         r_cdb_data    <= '0;
         r_busy        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_mul_type    <= w_dec_type;
                  r_hi_sel      <= w_dec_hi;
                  r_mul_a       <= i_iss_rs1_v;
                  r_mul_b       <= i_iss_rs2_v;
                  r_cdb_rob_idx <= i_iss_rob_idx;
                  r_cdb_pd      <= i_iss_pd;
                  r_busy        <= 1'b1;
                  if (w_zero) begin
                     // zero operand: the product is known, skip the multiplier
                     r_used      <= 1'b0;
                     r_cdb_data  <= '0;
                     r_cdb_valid <= 1'b1;
                     r_state     <= S_RESULT;
                  end else begin
                     r_used      <= 1'b1;
                     r_mul_start <= 1'b1;
                     r_state     <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               if (i_flush) begin
                  r_mul_start <= 1'b0;
                  r_state     <= i_mul_done ? S_COOL : S_DRAIN;
               end else if (i_mul_done) begin
                  r_mul_start <= 1'b0;
                  r_cdb_data  <= w_sel;
                  r_cdb_valid <= 1'b1;
                  r_state     <= S_RESULT;
               end
            end
            S_RESULT: begin
               if (i_flush || (r_cdb_valid && i_cdb_ready)) begin
                  r_cdb_valid <= 1'b0;
                  if (r_used) begin
                     r_state <= S_COOL;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            S_DRAIN: begin
               // killed op: let the multiplier finish, discard its product
               if (i_mul_done) r_state <= S_COOL;
            end
            S_COOL: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state     <= S_IDLE;
               r_mul_start <= 1'b0;
               r_cdb_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign o_mul_start   = r_mul_start;
   assign o_mul_type    = r_mul_type;
   assign o_mul_a       = r_mul_a;
   assign o_mul_b       = r_mul_b;
   assign o_cdb_valid   = r_cdb_valid;
   assign o_cdb_rob_idx = r_cdb_rob_idx;
   assign o_cdb_pd      = r_cdb_pd;
   assign o_cdb_data    = r_cdb_data;
   assign o_busy        = r_busy;

endmodule

// File: tb/tb_mul_fu_ctrl.sv
// Directed bench for mul_fu_ctrl with a behavioural start/done multiplier of
// adjustable latency; expected results are hand-computed constants.
module tb_mul_fu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        iss_valid;
   logic        iss_ready;
   logic [2:0]  iss_funct3;
   logic [31:0] iss_rs1_v;
   logic [31:0] iss_rs2_v;
   logic [4:0]  iss_rob_idx;
   logic [5:0]  iss_pd;
   logic        mul_start;
   logic [1:0]  mul_type;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic [63:0] mul_p;
   logic        mul_done;
   logic        cdb_valid;
   logic        cdb_ready;
   logic [4:0]  cdb_rob_idx;
   logic [5:0]  cdb_pd;
   logic [31:0] cdb_data;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   int lat      = 4;
   int start_cycles = 0;
   int m_cnt;
   logic m_run;

   always #5 clk = ~clk;

   mul_fu_ctrl #(.WIDTH(32), .ROB_IDX_W(5), .PREG_W(6)) dut (
      .clk(clk), .rst(rst), .i_flush(flush),
      .i_iss_valid(iss_valid), .o_iss_ready(iss_ready), .i_iss_funct3(iss_funct3),
      .i_iss_rs1_v(iss_rs1_v), .i_iss_rs2_v(iss_rs2_v),
      .i_iss_rob_idx(iss_rob_idx), .i_iss_pd(iss_pd),
      .o_mul_start(mul_start), .o_mul_type(mul_type), .o_mul_a(mul_a), .o_mul_b(mul_b),
      .i_mul_p(mul_p), .i_mul_done(mul_done),
      .o_cdb_valid(cdb_valid), .i_cdb_ready(cdb_ready),
      .o_cdb_rob_idx(cdb_rob_idx), .o_cdb_pd(cdb_pd), .o_cdb_data(cdb_data),
      .o_busy(busy)
   );

   function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] t);
      logic [63:0] ea, eb;
      ea = (t == 2'd1 || t == 2'd2) ? {{32{a[31]}}, a} : {32'h0, a};
      eb = (t == 2'd1) ? {{32{b[31]}}, b} : {32'h0, b};
      return ea * eb;
   endfunction

   // Multiplier model: start -> run lat cycles -> done held until start drops
   always @(posedge clk) begin
      if (mul_start) start_cycles <= start_cycles + 1;
      if (rst) begin
         m_run <= 1'b0; mul_done <= 1'b0; m_cnt <= 0; mul_p <= '0;
      end else if (mul_done) begin
         if (!mul_start) mul_done <= 1'b0;
      end else if (m_run) begin
         if (m_cnt <= 1) begin m_run <= 1'b0; mul_done <= 1'b1; end
         else m_cnt <= m_cnt - 1;
      end else if (mul_start) begin
         m_run <= 1'b1; m_cnt <= lat; mul_p <= prod(mul_a, mul_b, mul_type);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rob, input logic [5:0] pd);
      @(negedge clk);
      check("iss_ready_before_issue", 64'(iss_ready), 64'd1);
      iss_valid = 1'b1; iss_funct3 = f3; iss_rs1_v = a; iss_rs2_v = b;
      iss_rob_idx = rob; iss_pd = pd;
      @(posedge clk);
      #1 iss_valid = 1'b0;
   endtask

   // Leaves the bench at the negedge where cdb_valid is first seen
   task automatic wait_cdb(input string tag, output int cyc);
      cyc = 1;
      while (!cdb_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_cdb_timeout"}, 64'(cdb_valid), 64'd1);
   endtask

   task automatic grant(input string tag, input logic used);
      cdb_ready = 1'b1;
      @(posedge clk);
      #1 cdb_ready = 1'b0;
      @(negedge clk);
      check({tag, "_valid_after_grant"}, 64'(cdb_valid), 64'd0);
      check({tag, "_ready_after_grant"}, 64'(iss_ready), 64'(!used));
      if (used) begin
         @(negedge clk);
         check({tag, "_ready_after_cool"}, 64'(iss_ready), 64'd1);
         check({tag, "_busy_after_cool"}, 64'(busy), 64'd0);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rob, input logic [5:0] pd,
                         input logic [31:0] exp_data, input logic [1:0] exp_type,
                         input logic used);
      int cyc;
      int starts0;
      starts0 = start_cycles;
      issue(f3, a, b, rob, pd);
      @(negedge clk);
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_start"}, 64'(mul_start), 64'(used));
      if (used) begin
         check({tag, "_type"}, 64'(mul_type), 64'(exp_type));
         check({tag, "_a"}, 64'(mul_a), 64'(a));
      end
      wait_cdb(tag, cyc);
      check({tag, "_one_cycle"}, 64'(cyc == 1), 64'(!used));
      check({tag, "_data"}, 64'(cdb_data), 64'(exp_data));
      check({tag, "_rob"}, 64'(cdb_rob_idx), 64'(rob));
      check({tag, "_pd"}, 64'(cdb_pd), 64'(pd));
      check({tag, "_start_low"}, 64'(mul_start), 64'd0);
      check({tag, "_iss_ready_low"}, 64'(iss_ready), 64'd0);
      if (!used) check({tag, "_no_start"}, 64'(start_cycles - starts0), 64'd0);
      grant(tag, used);
   endtask

   initial begin
      int n;
      logic done_seen, got_valid;
      logic [31:0] held;
      rst = 1'b1; flush = 1'b0; iss_valid = 1'b0; iss_funct3 = '0;
      iss_rs1_v = '0; iss_rs2_v = '0; iss_rob_idx = '0; iss_pd = '0; cdb_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_iss_ready", 64'(iss_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_start", 64'(mul_start), 64'd0);
      check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
      check("rst_cdb_data", 64'(cdb_data), 64'd0);
      check("rst_mul_a", 64'(mul_a), 64'd0);

      run_op("mul", 3'b000, 32'd7, 32'd6, 5'd3, 6'd9, 32'h0000002A, 2'd0, 1'b1);
      run_op("mulh", 3'b001, 32'hFFFFFFFD, 32'd5, 5'd4, 6'd10, 32'hFFFFFFFF, 2'd1, 1'b1);
      run_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 6'd11, 32'hFFFFFFFE, 2'd0, 1'b1);
      run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 5'd6, 6'd12, 32'hFFFFFFFF, 2'd2, 1'b1);
      run_op("f3_100", 3'b100, 32'hFFFFFFFF, 32'd3, 5'd7, 6'd13, 32'hFFFFFFFD, 2'd0, 1'b1);
      lat = 1;
      run_op("mulh_min", 3'b001, 32'h80000000, 32'h80000000, 5'd31, 6'd63, 32'h40000000, 2'd1, 1'b1);
      lat = 4;
      run_op("zero", 3'b000, 32'd0, 32'h1234, 5'd8, 6'd14, 32'd0, 2'd0, 1'b0);
      run_op("zero_b", 3'b011, 32'hDEADBEEF, 32'd0, 5'd9, 6'd15, 32'd0, 2'd0, 1'b0);

      // CDB backpressure
      issue(3'b000, 32'd100, 32'd200, 5'd10, 6'd20);
      @(negedge clk);
      wait_cdb("bp", n);
      held = cdb_data;
      check("bp_data", 64'(held), 64'h4E20);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_valid_hold", 64'(cdb_valid), 64'd1);
         check("bp_data_hold", 64'(cdb_data), 64'(held));
         check("bp_iss_ready", 64'(iss_ready), 64'd0);
      end
      grant("bp", 1'b1);

      // Flush 5 cycles into BUSY with a slow multiplier
      lat = 8;
      issue(3'b000, 32'd11, 32'd13, 5'd11, 6'd21);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("fl_busy_start", 64'(mul_start), 64'd1);
      end
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("fl_start_drop", 64'(mul_start), 64'd0);
      check("fl_busy", 64'(busy), 64'd1);
      check("fl_mul_done_pending", 64'(mul_done), 64'd0);
      n = 0; done_seen = 1'b0; got_valid = 1'b0;
      while (busy && n < 100) begin
         if (mul_done) done_seen = 1'b1;
         if (cdb_valid || iss_ready) got_valid = 1'b1;
         @(negedge clk);
         n++;
      end
      check("fl_drain_timeout", 64'(busy), 64'd0);
      check("fl_done_seen", 64'(done_seen), 64'd1);
      check("fl_no_valid_or_ready", 64'(got_valid), 64'd0);
      check("fl_ready_after", 64'(iss_ready), 64'd1);
      lat = 4;
      run_op("after_fl", 3'b000, 32'd3, 32'd4, 5'd12, 6'd22, 32'd12, 2'd0, 1'b1);

      // Flush coinciding with mul_done goes straight to COOL
      issue(3'b001, 32'd9, 32'd9, 5'd13, 6'd23);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mul_done && n < 100);
      check("fd_done_timeout", 64'(mul_done), 64'd1);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("fd_valid", 64'(cdb_valid), 64'd0);
      check("fd_start", 64'(mul_start), 64'd0);
      check("fd_busy_cool", 64'(busy), 64'd1);
      @(negedge clk);
      check("fd_busy_idle", 64'(busy), 64'd0);
      check("fd_ready_idle", 64'(iss_ready), 64'd1);

      // Flush with a CDB grant in RESULT
      issue(3'b000, 32'd5, 32'd5, 5'd14, 6'd24);
      @(negedge clk);
      wait_cdb("fr", n);
      check("fr_data", 64'(cdb_data), 64'd25);
      flush = 1'b1; cdb_ready = 1'b1;
      @(posedge clk);
      #1 begin flush = 1'b0; cdb_ready = 1'b0; end
      @(negedge clk);
      check("fr_valid_drop", 64'(cdb_valid), 64'd0);
      check("fr_cool", 64'(iss_ready), 64'd0);
      @(negedge clk);
      check("fr_idle", 64'(iss_ready), 64'd1);

      // Flush of a zero-operand result returns straight to IDLE
      issue(3'b000, 32'd0, 32'd1, 5'd15, 6'd25);
      @(negedge clk);
      check("fz_valid", 64'(cdb_valid), 64'd1);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("fz_valid_drop", 64'(cdb_valid), 64'd0);
      check("fz_idle", 64'(iss_ready), 64'd1);

      // Flush in IDLE blocks acceptance
      @(negedge clk);
      flush = 1'b1; iss_valid = 1'b1; iss_rs1_v = 32'd2; iss_rs2_v = 32'd2;
      #1 check("fi_ready", 64'(iss_ready), 64'd0);
      @(posedge clk);
      #1 begin flush = 1'b0; iss_valid = 1'b0; end
      @(negedge clk);
      check("fi_busy", 64'(busy), 64'd0);
      check("fi_start", 64'(mul_start), 64'd0);

      // Reset mid-operation
      issue(3'b001, 32'd9, 32'd9, 5'd16, 6'd26);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mr_busy", 64'(busy), 64'd0);
      check("mr_start", 64'(mul_start), 64'd0);
      check("mr_type", 64'(mul_type), 64'd0);
      check("mr_mul_a", 64'(mul_a), 64'd0);
      check("mr_rob", 64'(cdb_rob_idx), 64'd0);
      check("mr_ready", 64'(iss_ready), 64'd1);
      run_op("after_rst", 3'b011, 32'h00010000, 32'h00010000, 5'd17, 6'd27, 32'd1, 2'd0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
